// File: rtl/simple_uart_pkg.sv
// Shared constants, RX state encoding and bit-period helper for simple_uart.
package simple_uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DUMMY_BITS = 15;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Divider values below 2 would make the half-period sample point degenerate.
  function automatic logic [31:0] bit_period(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

endpackage

// File: rtl/simple_uart_rx.sv
// RX path: 2-flop synchroniser, start/data/stop sampling FSM and 1-byte buffer.
// Optional sticky overrun flag under SIMPLE_UART_RX_STATUS_EN.
//
// state | meaning
// IDLE  | waiting for the synced line to go low
// START | half-period wait, then confirm start bit still low
// DATA  | sampling 8 data bits at full-period spacing, LSB first
// STOP  | sampling stop bit; latch byte only if high
module simple_uart_rx
  import simple_uart_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ser_rx,
  input  logic [31:0] i_period,
  input  logic        i_re,
  output logic        o_valid,
`ifdef SIMPLE_UART_RX_STATUS_EN
  output logic        o_overrun,
`endif
  output logic [7:0]  o_data
);

  logic [1:0]  r_sync;
  rx_state_e   r_state;
  rx_state_e   w_next;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        w_rx;
  logic        w_tc;
  logic        w_load_half;
  logic        w_load_full;
  logic        w_shift;
  logic        w_latch;

  assign w_rx = r_sync[1];
  assign w_tc = (r_cnt == 32'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_ser_rx};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_next = START;
      START:   if (w_tc) w_next = w_rx ? IDLE : DATA;
      DATA:    if (w_tc && (r_bit_idx == 3'(DATA_BITS - 1))) w_next = STOP;
      STOP:    if (w_tc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE:  w_load_half = !w_rx;
      START: w_load_full = w_tc && !w_rx;
      DATA: begin
        w_load_full = w_tc;
        w_shift     = w_tc;
      end
      STOP:  w_latch = w_tc && w_rx;
      default: ;
    endcase
  end

  // Timer reloads from the live period, so a divider change lands at the next bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= 32'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      if (w_load_half)      r_cnt <= (i_period >> 1) - 32'd1;
      else if (w_load_full) r_cnt <= i_period - 32'd1;
      else if (!w_tc)       r_cnt <= r_cnt - 32'd1;
      if (w_load_half)  r_bit_idx <= 3'd0;
      else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_latch) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else if (i_re) begin
      r_valid <= 1'b0;
    end
  end

`ifdef SIMPLE_UART_RX_STATUS_EN
  logic r_overrun;

  // A pop on the same edge as a new byte retires the old one, so it is not an overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst)                              r_overrun <= 1'b0;
    else if (w_latch && r_valid && !i_re)   r_overrun <= 1'b1;
    else if (i_re)                          r_overrun <= 1'b0;
  end

  assign o_overrun = r_overrun;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/simple_uart.sv
// Memory-mapped 8N1 UART top: baud divider, TX shifter with settle period, RX instance.
// Optional RX status bits in reg_dat_do under SIMPLE_UART_RX_STATUS_EN.
module simple_uart
  import simple_uart_pkg::*;
#(
  parameter logic [31:0] DIV_RESET = 32'd139
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  logic [31:0] r_div;
  logic        r_dummy;
  logic [9:0]  r_tx_shift;
  logic [3:0]  r_tx_bits;
  logic [31:0] r_tx_cnt;
  logic        r_ser_tx;
  logic [31:0] w_period;
  logic        w_tx_busy;
  logic        w_tx_accept;
  logic        w_dummy_start;
  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_unused_di;

  assign w_period      = bit_period(r_div);
  // A divider write in flight counts as busy so a simultaneous data write stalls.
  assign w_tx_busy     = (r_tx_bits != 4'd0) || r_dummy || (|reg_div_we);
  assign w_tx_accept   = reg_dat_we && !w_tx_busy;
  assign w_dummy_start = r_dummy && (r_tx_bits == 4'd0);
  assign reg_dat_wait  = reg_dat_we && w_tx_busy;
  assign reg_div_do    = r_div;
  assign ser_tx        = r_ser_tx;
  assign w_unused_di   = ^reg_dat_di[31:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= DIV_RESET;
      r_dummy <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) r_div[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
      if (|reg_div_we)        r_dummy <= 1'b1;
      else if (w_dummy_start) r_dummy <= 1'b0;
    end
  end

  // The settle period reuses the shifter: an all-ones frame of DUMMY_BITS bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shift <= '1;
      r_tx_bits  <= 4'd0;
      r_tx_cnt   <= 32'd0;
      r_ser_tx   <= 1'b1;
    end else if (w_tx_accept) begin
      r_tx_shift <= {1'b1, reg_dat_di[7:0], 1'b0};
      r_tx_bits  <= 4'(FRAME_BITS);
      r_tx_cnt   <= w_period - 32'd1;
      r_ser_tx   <= 1'b0;
    end else if (w_dummy_start) begin
      r_tx_shift <= '1;
      r_tx_bits  <= 4'(DUMMY_BITS);
      r_tx_cnt   <= w_period - 32'd1;
      r_ser_tx   <= 1'b1;
    end else if (r_tx_bits != 4'd0) begin
      if (r_tx_cnt == 32'd0) begin
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_bits  <= r_tx_bits - 4'd1;
        r_tx_cnt   <= w_period - 32'd1;
        r_ser_tx   <= r_tx_shift[1];
      end else begin
        r_tx_cnt <= r_tx_cnt - 32'd1;
      end
    end
  end

`ifdef SIMPLE_UART_RX_STATUS_EN
  logic w_rx_overrun;

  simple_uart_rx u_rx (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ser_rx  (ser_rx),
    .i_period  (w_period),
    .i_re      (reg_dat_re),
    .o_valid   (w_rx_valid),
    .o_overrun (w_rx_overrun),
    .o_data    (w_rx_data)
  );

  assign reg_dat_do = {22'h0, w_rx_overrun, w_rx_valid, (w_rx_valid ? w_rx_data : 8'h00)};
`else
  simple_uart_rx u_rx (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_ser_rx (ser_rx),
    .i_period (w_period),
    .i_re     (reg_dat_re),
    .o_valid  (w_rx_valid),
    .o_data   (w_rx_data)
  );

  assign reg_dat_do = w_rx_valid ? {24'h0, w_rx_data} : 32'h0;
`endif

endmodule

// File: tb/tb_simple_uart.sv
// Directed, table-driven bench for simple_uart (divider, TX framing/stall, RX buffer).
module tb_simple_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_tx;
  logic        ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int checks   = 0;
  int failures = 0;

`ifdef SIMPLE_UART_RX_STATUS_EN
  localparam logic [31:0] VB = 32'h100;
  localparam logic [31:0] OV = 32'h200;
`else
  localparam logic [31:0] VB = 32'h0;
  localparam logic [31:0] OV = 32'h0;
`endif

  typedef struct {
    logic [3:0]  we;
    logic [31:0] di;
    logic [31:0] exp;
  } div_vec_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        pop;
    logic [31:0] exp;
  } rx_vec_t;

  div_vec_t   dtab[6];
  rx_vec_t    rtab[7];
  logic [9:0] frame;
  int         n;
  bit         ok;

  always #5 clk = ~clk;

  simple_uart dut (
    .clk          (clk),
    .rst          (rst),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_div(input logic [3:0] we, input logic [31:0] di);
    reg_div_we = we;
    reg_div_di = di;
    tick();
    reg_div_we = 4'd0;
  endtask

  // Samples reg_dat_wait on falling edges until it drops; n = stalled cycles seen.
  task automatic wait_ready(input int budget, output int cnt, output bit done);
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < budget) begin
      @(negedge clk);
      if (!reg_dat_wait) done = 1'b1;
      else cnt++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      ser_rx = f[k];
      repeat (16) tick();
    end
    ser_rx = 1'b1;
    repeat (32) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dtab[0] = '{4'b0011, 32'h0000_0010, 32'h0000_0010};
    dtab[1] = '{4'b1000, 32'hAB00_0000, 32'hAB00_0010};
    dtab[2] = '{4'b0100, 32'h00CD_0000, 32'hABCD_0010};
    dtab[3] = '{4'b1111, 32'h0000_0003, 32'h0000_0003};
    dtab[4] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0003};
    dtab[5] = '{4'b0001, 32'h0000_0010, 32'h0000_0010};

    rtab[0] = '{8'hA3, 1'b1, 1'b1, 32'hA3 | VB};
    rtab[1] = '{8'h5A, 1'b0, 1'b0, 32'h00};
    rtab[2] = '{8'h3C, 1'b1, 1'b0, 32'h3C | VB};
    rtab[3] = '{8'hC5, 1'b1, 1'b0, 32'hC5 | VB | OV};
    rtab[4] = '{8'h00, 1'b0, 1'b1, 32'hC5 | VB | OV};
    rtab[5] = '{8'hFF, 1'b1, 1'b1, 32'hFF | VB};
    rtab[6] = '{8'h80, 1'b1, 1'b1, 32'h80 | VB};

    rst        = 1'b1;
    ser_rx     = 1'b1;
    reg_div_we = 4'd0;
    reg_div_di = 32'd0;
    reg_dat_we = 1'b0;
    reg_dat_re = 1'b0;
    reg_dat_di = 32'd0;
    tick();
    do_reset();

    @(negedge clk);
    check("reset_div", reg_div_do, 32'd139);
    check("reset_ser_tx", ser_tx, 1'b1);
    check("reset_dat_do", reg_dat_do, 32'h0);

    for (int i = 0; i < 6; i++) begin
      write_div(dtab[i].we, dtab[i].di);
      @(negedge clk);
      check($sformatf("div_vec%0d", i), reg_div_do, dtab[i].exp);
    end

    // Divider write and data write together: data stalls behind the settle period.
    do_reset();
    reg_div_we = 4'b0011;
    reg_div_di = 32'h0000_0010;
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0000_0055;
    #1;
    check("simul_div_dat_wait", reg_dat_wait, 1'b1);
    tick();
    reg_div_we = 4'd0;
    @(negedge clk);
    check("lane_write_div", reg_div_do, 32'h10);
    wait_ready(400, n, ok);
    check("dummy_wait_bound", ok, 1'b1);
    checks++;
    if (!(n >= 239 && n <= 242)) begin
      failures++;
      $display("FAIL dummy_stall_len: got %0d cycles expected about 240", n);
    end
    tick();
    reg_dat_we = 1'b0;
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 8 : 16) @(negedge clk);
      check($sformatf("tx55_bit%0d", k), ser_tx, frame[k]);
    end
    repeat (12) @(negedge clk);
    check("tx_idle_after_frame", ser_tx, 1'b1);

    tick();
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0000_0000;
    #1;
    check("idle_write_no_stall", reg_dat_wait, 1'b0);
    tick();
    reg_dat_we = 1'b0;
    @(negedge clk);
    check("idle_write_start_bit", ser_tx, 1'b0);
    repeat (20) tick();
    rst        = 1'b1;
    reg_dat_we = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_tx_ser_tx", ser_tx, 1'b1);
    check("rst_mid_tx_wait", reg_dat_wait, 1'b0);
    check("rst_mid_tx_div", reg_div_do, 32'd139);
    tick();
    rst        = 1'b0;
    reg_dat_we = 1'b0;

    write_div(4'b0011, 32'h0000_0010);
    repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      send_frame(rtab[i].data, rtab[i].stop);
      @(negedge clk);
      check($sformatf("rx_vec%0d_do", i), reg_dat_do, rtab[i].exp);
      if (rtab[i].pop) begin
        tick();
        reg_dat_re = 1'b1;
        tick();
        reg_dat_re = 1'b0;
        @(negedge clk);
        check($sformatf("rx_vec%0d_pop", i), reg_dat_do, 32'h0);
      end
    end

    tick();
    ser_rx = 1'b0;
    repeat (4) tick();
    ser_rx = 1'b1;
    repeat (48) tick();
    @(negedge clk);
    check("rx_glitch_no_byte", reg_dat_do, 32'h0);

    // Divider 0 clamps to a 2-cycle bit period but reads back raw.
    tick();
    write_div(4'b1111, 32'h0);
    @(negedge clk);
    check("div_zero_readback", reg_div_do, 32'h0);
    tick();
    reg_dat_we = 1'b1;
    reg_dat_di = 32'h0000_0001;
    wait_ready(200, n, ok);
    check("div0_wait_bound", ok, 1'b1);
    tick();
    reg_dat_we = 1'b0;
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (ser_tx == 1'b0) n++;
      else ok = 1'b1;
    end
    check("div0_start_bit_len", 32'(n), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
